// File: rtl/cl_serial_seq.sv
// Bit-serial logic unit: sequences a single 1-bit logic cell over N-bit operands, LSB first.
// Holds the last completed result and a zero flag behind a start/busy/done handshake.

module cl (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] s,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (s)
            2'b00:   y = a & b;
            2'b01:   y = a | b;
            2'b10:   y = a ^ b;
            default: y = ~a;
        endcase
    end

endmodule

module cl_serial_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [1:0]   S,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero
);

    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [1:0]    state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [N-1:0]  acc;
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic          cl_out;
    logic [N-1:0]  acc_next;

    cl u_cl (
        .a (sa[0]),
        .b (sb[0]),
        .s (op),
        .y (cl_out)
    );

    // New bits enter at the MSB so that after N shifts bit 0 holds the first cell output.
    assign acc_next = {cl_out, acc[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            op     <= 2'b00;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= A;
                        sb    <= B;
                        op    <= S;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    // The counter stops at N-1 so it never wraps.
                    if (cnt == LAST) begin
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_cl_serial_seq.sv
// Directed self-checking bench for cl_serial_seq (N=8 main instance, N=2 corner instance).

module tb_cl_serial_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [1:0] s_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic [1:0] s2;
    logic       busy2;
    logic       done2;
    logic [1:0] result2;
    logic       zero2;

    int checks = 0;
    int errors = 0;

    cl_serial_seq #(.N(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .A      (a_in),
        .B      (b_in),
        .S      (s_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    cl_serial_seq #(.N(2)) dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start2),
        .A      (a2),
        .B      (b2),
        .S      (s2),
        .busy   (busy2),
        .done   (done2),
        .result (result2),
        .zero   (zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents operands with a one-cycle start pulse; returns in the first RUN cycle.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        s_in  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles up to a bound and leaves the bench in the cycle after the last busy one.
    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                         input logic [7:0] exp_res, input logic exp_zero);
        int n;
        applyStimulus(a, b, s);
        countBusy(n);
        checkOutput({tag, "_busy_cycles"}, n, 8);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_result"}, result, exp_res);
        checkOutput({tag, "_zero"}, zero, exp_zero);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        int done_count;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        s_in   = '0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        s2     = '0;

        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 8'h00);
        checkOutput("reset_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;

        runOp("and", 8'hCA, 8'h5C, 2'b00, 8'h48, 1'b0);
        runOp("or", 8'hCA, 8'h5C, 2'b01, 8'hDE, 1'b0);
        runOp("xor", 8'hCA, 8'h5C, 2'b10, 8'h96, 1'b0);
        runOp("not", 8'hCA, 8'h5C, 2'b11, 8'h35, 1'b0);
        runOp("not_bff", 8'hCA, 8'hFF, 2'b11, 8'h35, 1'b0);
        runOp("xor_zero", 8'hA5, 8'hA5, 2'b10, 8'h00, 1'b1);
        runOp("and_one", 8'h01, 8'h01, 2'b00, 8'h01, 1'b0);

        // Starts during RUN with different operands must be ignored.
        applyStimulus(8'hFF, 8'h0F, 2'b00);
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_count++;
            start = (i == 1 || i == 5);
            a_in  = 8'h00;
            b_in  = 8'hF0;
            s_in  = 2'b01;
            if (i == 8) checkOutput("ignore_result", result, 8'h0F);
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput("ignore_done_count", done_count, 1);

        // Back-to-back: start held through DONE goes straight into RUN.
        applyStimulus(8'hCA, 8'h5C, 2'b00);
        countBusy(n);
        checkOutput("b2b_first_done", done, 1);
        checkOutput("b2b_first_result", result, 8'h48);
        a_in  = 8'hCA;
        b_in  = 8'h5C;
        s_in  = 2'b01;
        start = 1'b1;
        @(negedge clk);
        checkOutput("b2b_no_idle", busy, 1);
        start = 1'b0;
        a_in  = 8'h00;
        countBusy(n);
        checkOutput("b2b_busy_cycles", n, 8);
        checkOutput("b2b_second_result", result, 8'hDE);

        // Reset in the middle of an operation.
        runOp("pre_reset", 8'hCA, 8'h5C, 2'b01, 8'hDE, 1'b0);
        applyStimulus(8'h12, 8'h34, 2'b01);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("prereset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 8'h00);
        checkOutput("abort_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("post_reset", 8'h3C, 8'h0F, 2'b10, 8'h33, 1'b0);

        // N=2 instance.
        @(negedge clk);
        a2     = 2'b10;
        b2     = 2'b11;
        s2     = 2'b00;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        checkOutput("n2_busy0", busy2, 1);
        @(negedge clk);
        checkOutput("n2_busy1", busy2, 1);
        @(negedge clk);
        checkOutput("n2_done", done2, 1);
        checkOutput("n2_result", result2, 2'b10);
        checkOutput("n2_zero", zero2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
